// File: rtl/id_interlock_ctrl.sv
// Stall-only interlock for the five-stage pipeline: tracks in-flight destinations in EX/MEM/WB and freezes ID on RAW hazards.
// Optional build macro ID_INTERLOCK_STATS_EN adds a saturating stall_cycles counter port.
module id_interlock_ctrl #(
    parameter int unsigned WB_BYPASS = 0
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_rn,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic [1:0]  id_pcsource,
    output logic        wpcir,
    output logic        bubble,
    output logic        flush_if
`ifdef ID_INTERLOCK_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic       ex_vld_q,   ex_vld_d;
    logic [4:0] ex_rn_q,    ex_rn_d;
    logic       ex_m2reg_q, ex_m2reg_d;
    logic       mem_vld_q,   mem_vld_d;
    logic [4:0] mem_rn_q,    mem_rn_d;
    logic       mem_m2reg_q, mem_m2reg_d;
    logic       wb_vld_q,   wb_vld_d;
    logic [4:0] wb_rn_q,    wb_rn_d;
    logic       wb_m2reg_q, wb_m2reg_d;

    logic ex_hit, mem_hit, wb_hit, stall;

    // The WB load flag is retained only so the slot record stays complete.
    logic wb_m2reg_unused;
    assign wb_m2reg_unused = wb_m2reg_q;

    function automatic logic slot_hit(
        input logic       vld,
        input logic [4:0] rn,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return vld & ((use_rs & (rs == rn)) | (use_rt & (rt == rn)));
    endfunction

    always_comb begin
        ex_hit  = slot_hit(ex_vld_q,  ex_rn_q,  id_rs, id_rt, id_use_rs, id_use_rt);
        mem_hit = slot_hit(mem_vld_q, mem_rn_q, id_rs, id_rt, id_use_rs, id_use_rt);
        wb_hit  = 1'b0;
        if (WB_BYPASS == 0) begin
            wb_hit = slot_hit(wb_vld_q, wb_rn_q, id_rs, id_rt, id_use_rs, id_use_rt);
        end
        stall    = ex_hit | mem_hit | wb_hit;
        wpcir    = ~stall;
        bubble   = stall;
        flush_if = ~stall & (id_pcsource != 2'b00);
    end

    // Writes to r0 are entered invalid so register 0 can never raise a hazard.
    always_comb begin
        ex_vld_d    = ~stall & id_wreg & (id_rn != 5'd0);
        ex_rn_d     = id_rn;
        ex_m2reg_d  = id_m2reg;
        mem_vld_d   = ex_vld_q;
        mem_rn_d    = ex_rn_q;
        mem_m2reg_d = ex_m2reg_q;
        wb_vld_d    = mem_vld_q;
        wb_rn_d     = mem_rn_q;
        wb_m2reg_d  = mem_m2reg_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ex_vld_q  <= 1'b0;
            mem_vld_q <= 1'b0;
            wb_vld_q  <= 1'b0;
        end else begin
            ex_vld_q  <= ex_vld_d;
            mem_vld_q <= mem_vld_d;
            wb_vld_q  <= wb_vld_d;
        end
    end

    // Slot payloads are qualified by the valids, so they carry no reset.
    always_ff @(posedge clk) begin
        ex_rn_q     <= ex_rn_d;
        ex_m2reg_q  <= ex_m2reg_d;
        mem_rn_q    <= mem_rn_d;
        mem_m2reg_q <= mem_m2reg_d;
        wb_rn_q     <= wb_rn_d;
        wb_m2reg_q  <= wb_m2reg_d;
    end

`ifdef ID_INTERLOCK_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_id_interlock_ctrl.sv
// Scoreboard bench for id_interlock_ctrl: runs instruction programs through a history-list model for both WB_BYPASS settings.
module tb_id_interlock_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rn;
        logic       use_rs;
        logic       use_rt;
        logic       wreg;
        logic       m2reg;
        logic [1:0] pcs;
    } instr_t;

    typedef struct packed {
        logic [1:0]  stall;
        logic [1:0]  flush;
        logic [31:0] cnt0;
        logic [31:0] cnt1;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clrn = 1'b0;
    logic [4:0] id_rs [2];
    logic [4:0] id_rt [2];
    logic [4:0] id_rn [2];
    logic       id_use_rs [2];
    logic       id_use_rt [2];
    logic       id_wreg [2];
    logic       id_m2reg [2];
    logic [1:0] id_pcsource [2];
    logic       wpcir [2];
    logic       bubble [2];
    logic       flush_if [2];
`ifdef ID_INTERLOCK_STATS_EN
    logic [31:0] sc [2];
`endif

    id_interlock_ctrl #(.WB_BYPASS(0)) dut0 (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs[0]), .id_rt(id_rt[0]), .id_use_rs(id_use_rs[0]), .id_use_rt(id_use_rt[0]),
        .id_rn(id_rn[0]), .id_wreg(id_wreg[0]), .id_m2reg(id_m2reg[0]), .id_pcsource(id_pcsource[0]),
        .wpcir(wpcir[0]), .bubble(bubble[0]), .flush_if(flush_if[0])
`ifdef ID_INTERLOCK_STATS_EN
        , .stall_cycles(sc[0])
`endif
    );

    id_interlock_ctrl #(.WB_BYPASS(1)) dut1 (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs[1]), .id_rt(id_rt[1]), .id_use_rs(id_use_rs[1]), .id_use_rt(id_use_rt[1]),
        .id_rn(id_rn[1]), .id_wreg(id_wreg[1]), .id_m2reg(id_m2reg[1]), .id_pcsource(id_pcsource[1]),
        .wpcir(wpcir[1]), .bubble(bubble[1]), .flush_if(flush_if[1])
`ifdef ID_INTERLOCK_STATS_EN
        , .stall_cycles(sc[1])
`endif
    );

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];
    instr_t prog[$];

    // Reference state: destinations of the last three instructions that left ID (0 = nothing written).
    int hist [2][3];
    int pc [2];
    logic [31:0] cnt [2];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, d, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input int rn, input bit wreg, input bit m2reg,
                                  input int rs, input bit use_rs, input int rt, input bit use_rt,
                                  input int pcs);
        instr_t i;
        i.rn = 5'(rn); i.wreg = wreg; i.m2reg = m2reg;
        i.rs = 5'(rs); i.use_rs = use_rs; i.rt = 5'(rt); i.use_rt = use_rt;
        i.pcs = 2'(pcs);
        return i;
    endfunction

    // A source waits while any producer still ahead of it (3 deep, or 2 with write-through) targets it.
    function automatic bit model_stall(input int d, input instr_t i);
        int depth;
        depth = (d == 0) ? 3 : 2;
        for (int k = 0; k < depth; k++) begin
            if (hist[d][k] != 0 &&
                ((i.use_rs && int'(i.rs) == hist[d][k]) || (i.use_rt && int'(i.rt) == hist[d][k])))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input bit rst_now);
        exp_t   e;
        instr_t ins;
        bit     st;
        @(posedge clk);
        #1;
        clrn = !rst_now;
        if (rst_now) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 3; k++) hist[d][k] = 0;
                cnt[d] = 32'd0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            ins = (pc[d] < prog.size()) ? prog[pc[d]] : instr_t'(0);
            id_rs[d] = ins.rs; id_rt[d] = ins.rt; id_rn[d] = ins.rn;
            id_use_rs[d] = ins.use_rs; id_use_rt[d] = ins.use_rt;
            id_wreg[d] = ins.wreg; id_m2reg[d] = ins.m2reg; id_pcsource[d] = ins.pcs;
            st = model_stall(d, ins);
            e.stall[d] = st;
            e.flush[d] = !st && (ins.pcs != 2'b00);
            if (d == 0) e.cnt0 = cnt[0]; else e.cnt1 = cnt[1];
            if (!rst_now) begin
                hist[d][2] = hist[d][1];
                hist[d][1] = hist[d][0];
                hist[d][0] = (st || !ins.wreg) ? 0 : int'(ins.rn);
                if (st) begin
                    if (cnt[d] != 32'hFFFF_FFFF) cnt[d] = cnt[d] + 32'd1;
                end else if (pc[d] < prog.size()) begin
                    pc[d]++;
                end
            end
        end
        sbq.push_back(e);
    endtask

    task automatic run_prog(input int reset_at);
        int cyc;
        int budget;
        cyc = 0;
        pc[0] = 0;
        pc[1] = 0;
        budget = 4 * prog.size() + 8;
        while ((pc[0] < prog.size() || pc[1] < prog.size()) && cyc < budget) begin
            step(cyc == reset_at);
            cyc++;
        end
        chk("prog_done", 0, 32'(pc[0] >= prog.size() && pc[1] >= prog.size()), 32'd1);
        step(1'b0);
        step(1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int d = 0; d < 2; d++) begin
                    chk("wpcir", d, 32'(wpcir[d]), 32'(!e.stall[d]));
                    chk("bubble", d, 32'(bubble[d]), 32'(e.stall[d]));
                    chk("flush_if", d, 32'(flush_if[d]), 32'(e.flush[d]));
                end
`ifdef ID_INTERLOCK_STATS_EN
                chk("stall_cycles", 0, sc[0], e.cnt0);
                chk("stall_cycles", 1, sc[1], e.cnt1);
`endif
            end
        end
    end

    initial begin : stim
        int n;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) hist[d][k] = 0;
            pc[d] = 0;
            cnt[d] = 32'd0;
            id_rs[d] = '0; id_rt[d] = '0; id_rn[d] = '0; id_use_rs[d] = 1'b0; id_use_rt[d] = 1'b0;
            id_wreg[d] = 1'b0; id_m2reg[d] = 1'b0; id_pcsource[d] = 2'b00;
        end

        // Reset state, including a taken branch seen while reset is held.
        prog = '{mk(0, 0, 0, 8, 1, 9, 1, 1), mk(0, 0, 0, 0, 0, 0, 0, 0)};
        step(1'b1);
        run_prog(0);

        // add r3,r1,r2 ; add r4,r3,r5
        prog = '{mk(3, 1, 0, 1, 1, 2, 1, 0), mk(4, 1, 0, 3, 1, 5, 1, 0)};
        run_prog(-1);

        // One independent instruction between producer and consumer.
        prog = '{mk(3, 1, 0, 1, 1, 2, 1, 0), mk(7, 1, 0, 8, 1, 9, 1, 0), mk(4, 1, 0, 3, 1, 5, 1, 0)};
        run_prog(-1);

        // lw r2,0(r1) ; ori r6,r0,1 ; sw r2,0(r1)
        prog = '{mk(2, 1, 1, 1, 1, 2, 0, 0), mk(6, 1, 0, 0, 1, 6, 0, 0), mk(0, 0, 0, 1, 1, 2, 1, 0)};
        run_prog(-1);

        // Writes to r0 followed by readers of r0.
        prog = '{mk(0, 1, 0, 1, 1, 2, 1, 0), mk(0, 1, 1, 3, 1, 0, 0, 0), mk(5, 1, 0, 0, 1, 0, 1, 0)};
        run_prog(-1);

        // Independent beq, then add r3 and a dependent beq.
        prog = '{mk(0, 0, 0, 8, 1, 9, 1, 1), mk(3, 1, 0, 1, 1, 2, 1, 0), mk(0, 0, 0, 3, 1, 4, 1, 1)};
        run_prog(-1);

        // Reset in the second stall cycle of a 3-cycle stall.
        prog = '{mk(3, 1, 0, 1, 1, 2, 1, 0), mk(4, 1, 0, 3, 1, 5, 1, 0), mk(6, 1, 0, 4, 1, 4, 1, 0)};
        run_prog(2);

        // Dependent chain producing a long run of stalls after the reset.
        prog = '{mk(3, 1, 0, 1, 1, 2, 1, 0), mk(4, 1, 0, 3, 1, 5, 1, 0), mk(5, 1, 0, 4, 1, 0, 0, 0),
                 mk(6, 1, 0, 5, 0, 5, 1, 0), mk(0, 0, 0, 6, 1, 7, 1, 2)};
        run_prog(-1);

        // Randomised programs over a small register set so hazards are frequent.
        for (int r = 0; r < 3; r++) begin
            prog.delete();
            n = 150;
            for (int i = 0; i < n; i++) begin
                prog.push_back(mk($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                                  $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
            end
            run_prog((r == 1) ? $urandom_range(10, 100) : -1);
        end

        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 0, 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
